// File: rtl/config_loader_pkg.sv
// Shared definitions for the configuration loader.
//   state_t   : loader FSM states
//   calc_wpb  : bitstream words needed to cover one block image
//   idx_width : width of a block index for a given block count
package config_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    COMMIT,
    DONE
  } state_t;

  function automatic int unsigned calc_wpb(input int unsigned cw, input int unsigned iw);
    return (cw + iw - 1) / iw;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/config_word_assembler.sv
// Assembles WPB bitstream words (LSB-first) into one block image.
//   clk, rst : clock, synchronous active-high reset
//   i_clr    : clear image, word counter (and running XOR)
//   i_wr     : write i_data at the current word index, then advance
//   i_data   : bitstream word
//   o_last   : current index is the final word of the image
//   o_img    : image including the word being written this cycle,
//              truncated to CONF_WIDTH (padding bits dropped)
//   o_xor    : running XOR of written words (CONFIG_LOADER_CHECKSUM_EN only)
module config_word_assembler #(
  parameter int unsigned CONF_WIDTH = 88,
  parameter int unsigned IW         = 16,
  parameter int unsigned WPB        = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_wr,
  input  logic [IW-1:0]         i_data,
  output logic                  o_last,
`ifdef CONFIG_LOADER_CHECKSUM_EN
  output logic [IW-1:0]         o_xor,
`endif
  output logic [CONF_WIDTH-1:0] o_img
);

  localparam int unsigned CNW = $clog2(WPB + 1);

  logic [WPB*IW-1:0] r_img;
  logic [CNW-1:0]    r_cnt;
  logic [WPB*IW-1:0] w_img;

  // Merged view lets the owner register the full image on the same edge
  // that the final word arrives.
  always_comb begin
    w_img = r_img;
    if (i_wr) w_img[int'(r_cnt)*IW +: IW] = i_data;
  end

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_img <= '0;
      r_cnt <= '0;
    end else if (i_wr) begin
      r_img <= w_img;
      r_cnt <= r_cnt + CNW'(1);
    end
  end

`ifdef CONFIG_LOADER_CHECKSUM_EN
  logic [IW-1:0] r_xor;
  always_ff @(posedge clk) begin
    if (rst || i_clr)  r_xor <= '0;
    else if (i_wr)     r_xor <= r_xor ^ i_data;
  end
  assign o_xor = r_xor;
`endif

  assign o_last = (r_cnt == CNW'(WPB - 1));
  assign o_img  = w_img[CONF_WIDTH-1:0];

endmodule

// File: rtl/config_loader.sv
// Loads NBLK connection-block configuration images from a word-serial
// bitstream (valid/ready) and strobes each image into its block.
//   clk, rst  : clock, synchronous active-high reset
//   start     : begin a full load (sampled only when idle)
//   in_valid, in_data, in_ready : bitstream handshake
//   c         : registered config image shared by all blocks
//   cset      : one-hot capture strobe, high for one cycle per block
//   busy      : high from start acceptance until the done cycle ends
//   done      : one-cycle pulse at end of load
//   err       : sticky checksum error
// Optional feature macro CONFIG_LOADER_CHECKSUM_EN: each image is followed
// by an XOR checksum word; a mismatch aborts the load and sets err.
module config_loader
  import config_loader_pkg::*;
#(
  parameter int unsigned CONF_WIDTH = 88,
  parameter int unsigned IW         = 16,
  parameter int unsigned NBLK       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [IW-1:0]         in_data,
  output logic                  in_ready,
  output logic [CONF_WIDTH-1:0] c,
  output logic [NBLK-1:0]       cset,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned WPB = calc_wpb(CONF_WIDTH, IW);
  localparam int unsigned BW  = idx_width(NBLK);

  state_t                r_state;
  logic [BW-1:0]         r_blk;
  logic [CONF_WIDTH-1:0] r_c;
  logic [NBLK-1:0]       r_cset;
  logic                  r_in_ready;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_xfer;
  logic                  w_wr;
  logic                  w_clr;
  logic                  w_last;
  logic                  w_blk_last;
  logic [NBLK-1:0]       w_onehot;
  logic [CONF_WIDTH-1:0] w_img;

  assign w_xfer     = in_valid & r_in_ready;
  assign w_wr       = w_xfer & (r_state == LOAD);
  assign w_clr      = (r_state == IDLE) | (r_state == COMMIT);
  assign w_blk_last = (r_blk == BW'(NBLK - 1));
  assign w_onehot   = NBLK'(1) << r_blk;

`ifdef CONFIG_LOADER_CHECKSUM_EN
  logic [IW-1:0] w_xor;
  logic          r_err;
`endif

  config_word_assembler #(
    .CONF_WIDTH (CONF_WIDTH),
    .IW         (IW),
    .WPB        (WPB)
  ) u_asm (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_wr   (w_wr),
    .i_data (in_data),
    .o_last (w_last),
`ifdef CONFIG_LOADER_CHECKSUM_EN
    .o_xor  (w_xor),
`endif
    .o_img  (w_img)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_blk      <= '0;
      r_c        <= '0;
      r_cset     <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
      r_err      <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= LOAD;
            r_blk      <= '0;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b1;
`ifdef CONFIG_LOADER_CHECKSUM_EN
            r_err      <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (w_wr && w_last) begin
`ifdef CONFIG_LOADER_CHECKSUM_EN
            r_state    <= CHECK;
`else
            // c and cset register together so c is stable while cset is high.
            r_state    <= COMMIT;
            r_in_ready <= 1'b0;
            r_c        <= w_img;
            r_cset     <= w_onehot;
`endif
          end
        end
        CHECK: begin
`ifdef CONFIG_LOADER_CHECKSUM_EN
          if (w_xfer) begin
            r_in_ready <= 1'b0;
            if (in_data == w_xor) begin
              r_state <= COMMIT;
              r_c     <= w_img;
              r_cset  <= w_onehot;
            end else begin
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
`else
          r_state <= IDLE;
`endif
        end
        COMMIT: begin
          r_cset <= '0;
          if (w_blk_last) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_blk      <= r_blk + BW'(1);
            r_state    <= LOAD;
            r_in_ready <= 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready = r_in_ready;
  assign c        = r_c;
  assign cset     = r_cset;
  assign busy     = r_busy;
  assign done     = r_done;
`ifdef CONFIG_LOADER_CHECKSUM_EN
  assign err      = r_err;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_config_loader.sv
module tb_config_loader;

  localparam int unsigned CW   = 88;
  localparam int unsigned IW   = 16;
  localparam int unsigned NBLK = 4;
  localparam int unsigned WPB  = 6;
`ifdef CONFIG_LOADER_CHECKSUM_EN
  localparam int unsigned STRIDE = WPB + 1;
  localparam bit          CK     = 1'b1;
`else
  localparam int unsigned STRIDE = WPB;
  localparam bit          CK     = 1'b0;
`endif
  localparam int unsigned PER = STRIDE + 1;  // cycles per block at full rate

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            in_valid = 1'b0;
  logic [IW-1:0]   in_data = '0;
  logic            in_ready;
  logic [CW-1:0]   c;
  logic [NBLK-1:0] cset;
  logic            busy, done, err;

  config_loader #(.CONF_WIDTH(CW), .IW(IW), .NBLK(NBLK)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .c(c), .cset(cset), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [IW-1:0] stim [NBLK*STRIDE];

  // reference-model state: expectations for the current cycle
  bit              mv_busy = 0, mv_ready = 0, mv_done = 0, mv_err = 0;
  logic [NBLK-1:0] mv_cset = '0;
  logic [CW-1:0]   mv_c = '0;
  int              mv_blk = 0, mv_nw = 0;
  bit              mon_en = 0;

  int              start_cyc = 0;
  int              ev_n = 0;
  int              ev_cyc [64];
  logic [NBLK-1:0] ev_cset [64];
  logic [CW-1:0]   ev_c [64];
  int              done_n = 0;
  int              done_cyc = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Block image: words of block b concatenated LSB-first, truncated to CW bits.
  function automatic logic [CW-1:0] image(input int b);
    logic [WPB*IW-1:0] t, w;
    t = '0;
    for (int k = 0; k < WPB; k++) begin
      w = '0;
      w[IW-1:0] = stim[b*STRIDE+k];
      t = t | (w << (k*IW));
    end
    return t[CW-1:0];
  endfunction

  function automatic logic [IW-1:0] xsum(input int b);
    logic [IW-1:0] x;
    x = '0;
    for (int k = 0; k < WPB; k++) x = x ^ stim[b*STRIDE+k];
    return x;
  endfunction

  task automatic fix_checks();
`ifdef CONFIG_LOADER_CHECKSUM_EN
    for (int b = 0; b < NBLK; b++) stim[b*STRIDE+WPB] = xsum(b);
`endif
  endtask

  task automatic fill_stim();
    for (int i = 0; i < NBLK*STRIDE; i++) stim[i] = IW'($urandom);
    fix_checks();
  endtask

  // Per-cycle compare against the model, then advance the model from the
  // inputs and handshake seen this cycle.
  task automatic monitor();
    bit nb, nr, nd, ne;
    logic [NBLK-1:0] ncs;
    logic [CW-1:0] nc;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("busy", busy, mv_busy);
        check("in_ready", in_ready, mv_ready);
        check("done", done, mv_done);
        check("cset", cset, mv_cset);
        check("c", c, mv_c);
        check("err", err, mv_err);
      end
      if (cset != '0 && ev_n < 64) begin
        ev_cyc[ev_n] = cyc - start_cyc;
        ev_cset[ev_n] = cset;
        ev_c[ev_n] = c;
        ev_n++;
      end
      if (done) begin
        done_n++;
        done_cyc = cyc - start_cyc;
      end
      nb = mv_busy; nr = mv_ready; nd = 0; ncs = '0; nc = mv_c; ne = mv_err;
      if (rst) begin
        nb = 0; nr = 0; nc = '0; ne = 0;
        mv_blk = 0; mv_nw = 0; mon_en = 1;
      end else begin
        if (mv_done) nb = 0;
        if (!mv_busy && start) begin
          nb = 1; nr = 1; ne = 0; mv_blk = 0; mv_nw = 0;
        end else if (mv_cset != '0) begin
          if (mv_blk == NBLK-1) begin
            nd = 1;
          end else begin
            mv_blk++; mv_nw = 0; nr = 1;
          end
        end else if (mv_ready && in_valid) begin
          mv_nw++;
          if (mv_nw == STRIDE) begin
            nr = 0;
            if (!CK || in_data == xsum(mv_blk)) begin
              ncs = NBLK'(1) << mv_blk;
              nc = image(mv_blk);
            end else begin
              ne = 1; nd = 1;
            end
          end
        end
      end
      mv_busy = nb; mv_ready = nr; mv_done = nd; mv_cset = ncs; mv_c = nc; mv_err = ne;
    end
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Streams stim[0..n-1]; in_data held until transferred. Optional start
  // pulse while word pulse_at is pending.
  task automatic feed(input int n, input int gap_pct, input int pulse_at);
    int idx = 0;
    int budget = 4000;
    bit x;
    while (idx < n && budget > 0) begin
      in_valid = ($urandom_range(99) >= gap_pct);
      in_data  = stim[idx];
      start    = (idx == pulse_at);
      @(negedge clk);
      x = in_valid && in_ready;
      @(posedge clk); #1;
      if (x) idx++;
      budget--;
    end
    in_valid = 1'b0;
    start = 1'b0;
    check("feed_words", idx, n);
  endtask

  task automatic wait_done();
    int b = 0;
    while (!done && b < 500) begin
      @(negedge clk);
      b++;
    end
    check("done_seen", done, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic main_seq();
    int base, base2, d0;
    // reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_c", c, '0);
    check("reset_cset", cset, '0);
    check("reset_ready", in_ready, 1'b0);
    check("reset_busy", busy, 1'b0);

    // full-rate load; block 0 exercises the truncated padding word
    fill_stim();
    for (int k = 0; k < 5; k++) stim[k] = '0;
    stim[5] = 16'hFFFF;
    fix_checks();
    check("model_img0", image(0), {8'hFF, 80'h0});
    base = ev_n;
    do_start();
    feed(NBLK*STRIDE, 0, -1);
    wait_done();
    check("t1_events", ev_n - base, NBLK);
    for (int k = 0; k < NBLK; k++) begin
      check("t1_cset_cyc", ev_cyc[base+k], (k+1)*PER);
      check("t1_cset_val", ev_cset[base+k], 1 << k);
    end
    check("t1_done_cyc", done_cyc, NBLK*PER + 1);
    check("t1_c0_pad", ev_c[base], {8'hFF, 80'h0});
    repeat (2) @(posedge clk);

    // random valid gaps
    fill_stim();
    base = ev_n;
    do_start();
    feed(NBLK*STRIDE, 50, -1);
    wait_done();
    check("t3_events", ev_n - base, NBLK);
    for (int k = 0; k < NBLK; k++) check("t3_order", ev_cset[base+k], 1 << k);

    // reset after 3 words of block 2
    fill_stim();
    base = ev_n;
    do_start();
    feed(2*STRIDE + 3, 30, -1);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t4_c_zero", c, '0);
    check("t4_busy_zero", busy, 1'b0);
    check("t4_ready_zero", in_ready, 1'b0);
    check("t4_events", ev_n - base, 2);
    base2 = ev_n;
    do_start();
    feed(NBLK*STRIDE, 0, -1);
    wait_done();
    check("t4_reload_blk0", ev_cset[base2], 4'b0001);
    check("t4_reload_c0", ev_c[base2], image(0));

    // start pulsed mid-load is ignored
    fill_stim();
    base = ev_n;
    d0 = done_n;
    do_start();
    feed(NBLK*STRIDE, 20, STRIDE + 2);
    wait_done();
    repeat (5) @(negedge clk);
    check("t5_done_count", done_n - d0, 1);
    check("t5_events", ev_n - base, NBLK);

`ifdef CONFIG_LOADER_CHECKSUM_EN
    // corrupt checksum on block 1
    fill_stim();
    stim[1*STRIDE+WPB] = stim[1*STRIDE+WPB] ^ 16'h0001;
    base = ev_n;
    d0 = done_n;
    do_start();
    feed(2*STRIDE, 0, -1);
    wait_done();
    repeat (3) @(negedge clk);
    check("t6_events", ev_n - base, 1);
    check("t6_cset0", ev_cset[base], 4'b0001);
    check("t6_err_held", err, 1'b1);
    check("t6_done_count", done_n - d0, 1);
    do_start();
    @(negedge clk);
    check("t6_err_cleared", err, 1'b0);
    fill_stim();
    feed(NBLK*STRIDE, 0, -1);
    wait_done();
`endif
    repeat (3) @(negedge clk);
  endtask

  initial begin
    fork
      monitor();
      main_seq();
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
